// File: rtl/team_02_wbm_pkg.sv
// team_02_wbm_pkg: shared state encoding and Wishbone widths for the team_02 master arbiter
package team_02_wbm_pkg;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;
endpackage

// File: rtl/team_02_wbm_arbiter_if.sv
// team_02_wbm_arbiter_if: Wishbone classic master/slave signal bundle
interface team_02_wbm_arbiter_if;
  import team_02_wbm_pkg::*;
  logic [WB_AW-1:0] ADR_O;
  logic [WB_DW-1:0] DAT_O;
  logic [WB_DW-1:0] DAT_I;
  logic [WB_SW-1:0] SEL_O;
  logic             WE_O;
  logic             STB_O;
  logic             CYC_O;
  logic             ACK_I;
  modport master (output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O, input DAT_I, ACK_I);
  modport slave  (input ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O, output DAT_I, ACK_I);
endinterface

// File: rtl/team_02_rr_pick.sv
// team_02_rr_pick: combinational round-robin picker searching upward from last_i+1
module team_02_rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic          found;
  logic [IW-1:0] k;
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last_i) + i) % N);
      if (!found && req_i[k]) begin
        found = 1'b1;
        idx_o = k;
      end
    end
    gnt_o        = '0;
    gnt_o[idx_o] = found;
  end
endmodule

// File: rtl/team_02_wbm_arbiter.sv
// team_02_wbm_arbiter: round-robin sequencer running one Wishbone classic single
// transfer per grant, with an ACK timeout that aborts unacknowledged cycles.
module team_02_wbm_arbiter
  import team_02_wbm_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       we_i,
  input  logic [NUM_REQ*WB_AW-1:0] adr_i,
  input  logic [NUM_REQ*WB_DW-1:0] dat_i,
  input  logic [NUM_REQ*WB_SW-1:0] sel_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     err_o,
  output logic [WB_DW-1:0]         rdata_o,
  team_02_wbm_arbiter_if.master    wb
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e             state_q;
  logic [IW-1:0]      last_q, idx_q, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt, gnt_q, done_q;
  logic [CW-1:0]      cnt_q;
  logic               err_q, we_q, cyc_q, expired;
  logic [WB_AW-1:0]   adr_q;
  logic [WB_DW-1:0]   dat_q, rdata_q;
  logic [WB_SW-1:0]   sel_q;
  team_02_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );
  // Counter holds the number of BUS cycles already spent; the TIMEOUT-th cycle aborts
  assign expired = cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          gnt_q   <= pick_gnt;
          idx_q   <= pick_idx;
          adr_q   <= adr_i[WB_AW*pick_idx +: WB_AW];
          dat_q   <= dat_i[WB_DW*pick_idx +: WB_DW];
          sel_q   <= sel_i[WB_SW*pick_idx +: WB_SW];
          we_q    <= we_i[pick_idx];
          cyc_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= BUS;
        end
        BUS: if (wb.ACK_I || expired) begin
          if (wb.ACK_I && !we_q) rdata_q <= wb.DAT_I;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          done_q  <= gnt_q;
          err_q   <= !wb.ACK_I;
          state_q <= DONE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          gnt_q   <= '0;
          last_q  <= idx_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign wb.ADR_O  = adr_q;
  assign wb.DAT_O  = dat_q;
  assign wb.SEL_O  = sel_q;
  assign wb.WE_O   = we_q;
  assign wb.CYC_O  = cyc_q;
  assign wb.STB_O  = cyc_q;
endmodule

// File: tb/tb_team_02_wbm_arbiter.sv
// tb_team_02_wbm_arbiter: directed and randomized checks of the arbiter against a
// transaction-level model (owner, BUS cycles spent, completion flag).
module tb_team_02_wbm_arbiter;
  localparam int NR = 2;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] req = '0, we = '0;
  logic [31:0] adr [NR];
  logic [31:0] dat [NR];
  logic [3:0]  sel [NR];
  logic [NR*32-1:0] adr_v, dat_v;
  logic [NR*4-1:0]  sel_v;
  logic [NR-1:0] gnt_o, done_o;
  logic err_o;
  logic [31:0] rdata_o;
  team_02_wbm_arbiter_if wb();
  team_02_wbm_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .adr_i(adr_v), .dat_i(dat_v),
    .sel_i(sel_v), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .wb(wb)
  );
  always #5 clk = ~clk;
  always_comb begin
    adr_v = '0;
    dat_v = '0;
    sel_v = '0;
    for (int k = 0; k < NR; k++) begin
      adr_v[32*k +: 32] = adr[k];
      dat_v[32*k +: 32] = dat[k];
      sel_v[4*k +: 4]   = sel[k];
    end
  end
  int n_tests = 0, n_fail = 0;
  bit rnd = 0, rearm = 0, dat_fix = 0;
  int ack_mode = 1, ack_k = 0, ack_pct = 50, bus_n = 0;
  logic [31:0] dat_fixv = '0;
  // model: who owns the bus, BUS cycles used, and whether the completion cycle is showing
  int owner = -1, last = NR - 1, nbus = 0;
  bit fin = 0, m_err = 0, e_we = 0;
  logic [31:0] e_adr = '0, e_dat = '0, e_rdata = '0;
  logic [3:0]  e_sel = '0;
  int x_cyc;
  logic [NR-1:0] x_dn;
  logic x_er, x_we;
  logic [31:0] x_adr, x_dat;
  logic [3:0] x_sel;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic model_step();
    if (rst) begin
      owner = -1; fin = 0; m_err = 0; last = NR - 1; nbus = 0;
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 0; e_rdata = '0;
    end else if (owner >= 0 && fin) begin
      last = owner; owner = -1; fin = 0; m_err = 0;
    end else if (owner >= 0) begin
      nbus++;
      if (wb.ACK_I) begin
        fin = 1;
        if (!e_we) e_rdata = wb.DAT_I;
      end else if (nbus == TO) begin
        fin = 1; m_err = 1;
      end
    end else if (req != 0) begin
      for (int i = 1; i <= NR; i++) begin
        automatic int k = (last + i) % NR;
        if (owner < 0 && req[k]) begin
          owner = k; e_adr = adr[k]; e_dat = dat[k]; e_sel = sel[k]; e_we = we[k];
        end
      end
      nbus = 0;
    end
  endtask
  task automatic compare();
    logic [NR-1:0] eg;
    bit cyc;
    eg = '0;
    if (!rst && owner >= 0) eg[owner] = 1'b1;
    cyc = !rst && owner >= 0 && !fin;
    chk("gnt_o", 32'(gnt_o), 32'(eg));
    chk("done_o", 32'(done_o), (fin && !rst) ? 32'(eg) : 32'd0);
    chk("err_o", 32'(err_o), 32'(!rst && fin && m_err));
    chk("CYC_O", 32'(wb.CYC_O), 32'(cyc));
    chk("STB_O", 32'(wb.STB_O), 32'(cyc));
    chk("WE_O", 32'(wb.WE_O), 32'(cyc && e_we));
    chk("ADR_O", wb.ADR_O, rst ? 32'd0 : e_adr);
    chk("DAT_O", wb.DAT_O, rst ? 32'd0 : e_dat);
    chk("SEL_O", 32'(wb.SEL_O), rst ? 32'd0 : 32'(e_sel));
    chk("rdata_o", rdata_o, rst ? 32'd0 : e_rdata);
  endtask
  task automatic drive();
    logic [NR-1:0] dropped;
    dropped = done_o;
    req = req & ~done_o;
    for (int k = 0; k < NR; k++) begin
      if ((rnd || rearm) && !req[k] && !dropped[k] && (rearm || $urandom_range(99) < 30)) begin
        req[k] = 1'b1; we[k] = 1'($urandom); adr[k] = $urandom; dat[k] = $urandom; sel[k] = 4'($urandom);
      end
      if (rnd && gnt_o[k]) begin
        adr[k] = $urandom; dat[k] = $urandom; sel[k] = 4'($urandom); we[k] = 1'($urandom);
      end
    end
    bus_n = wb.CYC_O ? bus_n + 1 : 0;
    wb.ACK_I = ack_mode == 0 ? ($urandom_range(99) < ack_pct) : ack_mode == 2 ? (bus_n == ack_k + 1) : 1'b0;
    wb.DAT_I = dat_fix ? dat_fixv : $urandom;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask
  task automatic run_xfer();
    x_cyc = 0; x_dn = '0; x_er = 0; x_adr = '0; x_dat = '0; x_sel = '0; x_we = 0;
    for (int i = 0; i < 64 && x_dn == 0; i++) begin
      tick();
      if (wb.CYC_O) begin
        x_cyc++;
        if (x_cyc == 1) begin
          x_adr = wb.ADR_O; x_dat = wb.DAT_O; x_sel = wb.SEL_O; x_we = wb.WE_O;
        end
      end
      if (done_o != 0) begin
        x_dn = done_o; x_er = err_o;
      end
    end
    chk("xfer_completed", 32'(x_dn != 0), 32'd1);
    tick();
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (req != 0 || gnt_o != 0); i++) tick();
    chk("drain", 32'(req != 0 || gnt_o != 0), 32'd0);
  endtask
  initial begin
    int got [$];
    logic [NR-1:0] pg;
    int n;
    for (int k = 0; k < NR; k++) begin
      adr[k] = '0; dat[k] = '0; sel[k] = '0;
    end
    wb.ACK_I = 1'b0;
    wb.DAT_I = '0;
    repeat (3) tick();
    chk("rst_cyc", 32'(wb.CYC_O), 32'd0);
    chk("rst_stb", 32'(wb.STB_O), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_adr", wb.ADR_O, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst = 1'b0;
    ack_mode = 2; ack_k = 2; dat_fix = 1; dat_fixv = 32'hDEAD_BEEF;
    adr[0] = 32'h3000_0010; we[0] = 1'b0; sel[0] = 4'hF; req = 2'b01;
    run_xfer();
    chk("rd_cyc_len", 32'(x_cyc), 32'd3);
    chk("rd_adr", x_adr, 32'h3000_0010);
    chk("rd_we", 32'(x_we), 32'd0);
    chk("rd_done", 32'(x_dn), 32'd1);
    chk("rd_err", 32'(x_er), 32'd0);
    chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    ack_k = 1;
    adr[1] = 32'h3000_0020; dat[1] = 32'h1234_5678; sel[1] = 4'b0011; we[1] = 1'b1; req = 2'b10;
    run_xfer();
    chk("wr_we", 32'(x_we), 32'd1);
    chk("wr_sel", 32'(x_sel), 32'h3);
    chk("wr_dat", x_dat, 32'h1234_5678);
    chk("wr_done", 32'(x_dn), 32'd2);
    chk("wr_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    ack_mode = 0; ack_pct = 50; dat_fix = 0; rearm = 1; req = 2'b11;
    pg = gnt_o;
    for (int i = 0; i < 400 && got.size() < 8; i++) begin
      tick();
      if (gnt_o != 0 && pg == 0) got.push_back(gnt_o[1] ? 1 : 0);
      pg = gnt_o;
    end
    chk("contention_count", 32'(got.size()), 32'd8);
    foreach (got[i]) chk($sformatf("order%0d", i), 32'(got[i]), 32'(i % 2));
    rearm = 0;
    drain();
    ack_mode = 1; we[0] = 1'b0; req = 2'b01;
    run_xfer();
    chk("to_cyc_len", 32'(x_cyc), 32'd8);
    chk("to_done", 32'(x_dn), 32'd1);
    chk("to_err", 32'(x_er), 32'd1);
    ack_mode = 2; ack_k = 0; we[1] = 1'b0; req = 2'b10;
    run_xfer();
    chk("after_to_cyc_len", 32'(x_cyc), 32'd1);
    chk("after_to_done", 32'(x_dn), 32'd2);
    chk("after_to_err", 32'(x_er), 32'd0);
    ack_k = 7; dat_fix = 1; dat_fixv = 32'hCAFE_F00D; req = 2'b01;
    run_xfer();
    chk("edge_cyc_len", 32'(x_cyc), 32'd8);
    chk("edge_err", 32'(x_er), 32'd0);
    chk("edge_rdata", rdata_o, 32'hCAFE_F00D);
    ack_mode = 1; req = 2'b01;
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      tick();
      if (wb.CYC_O) n++;
    end
    rst = 1'b1;
    #1;
    chk("async_cyc", 32'(wb.CYC_O), 32'd0);
    chk("async_stb", 32'(wb.STB_O), 32'd0);
    chk("async_gnt", 32'(gnt_o), 32'd0);
    req = '0;
    repeat (2) begin
      tick();
      chk("rst_no_done", 32'(done_o), 32'd0);
    end
    ack_mode = 2; ack_k = 0; we[1] = 1'b0; adr[1] = 32'h4000_0000;
    rst = 1'b0; req = 2'b10;
    tick();
    chk("post_rst_gnt", 32'(gnt_o), 32'd2);
    chk("post_rst_cyc", 32'(wb.CYC_O), 32'd1);
    run_xfer();
    chk("post_rst_done", 32'(x_dn), 32'd2);
    rnd = 1; ack_mode = 0; dat_fix = 0; ack_pct = 60;
    repeat (1000) tick();
    ack_pct = 15;
    repeat (1000) tick();
    rnd = 0;
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
